// File: rtl/reg_file_mp.sv
// Multi-port integer register file with all-port write forwarding, a per-register
// busy scoreboard and a sequential clear engine in place of a storage reset.
module reg_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_busy_o,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
    input  logic                         alloc_en_i,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr_i,
    input  logic                         clr_req_i,
    output logic                         ready_o
);

    localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
    localparam bit          ZeroEn = (ZERO_REG != 0);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [Depth-1:0]        busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   regs_q [Depth];
    logic                    idle;
    logic [NUM_WR-1:0]       wr_ok;

    assign idle    = (state_q == StIdle);
    assign ready_o = idle;

    // Storage-side write enable: only in IDLE, never into a hardwired x0.
    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok[j] = idle && wr_en_i[j] &&
                       !(ZeroEn && (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == '0));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            StClear: begin
                busy_d[cnt_q] = 1'b0;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(Depth - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en_i[j]) begin
                        busy_d[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
                    end
                end
                // Applied after the write clears so a same-cycle alloc wins.
                if (alloc_en_i && !(ZeroEn && (alloc_addr_i == '0))) begin
                    busy_d[alloc_addr_i] = 1'b1;
                end
                if (clr_req_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Later ports are assigned last, so the highest-index port wins a conflict.
    always_ff @(posedge clk) begin
        if (!idle) begin
            regs_q[cnt_q] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j]) begin
                    regs_q[wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] <=
                        wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] a;
        logic                  hit;
        logic [DATA_WIDTH-1:0] fwd;
        a         = '0;
        hit       = 1'b0;
        fwd       = '0;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a   = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            hit = 1'b0;
            fwd = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == a)) begin
                    hit = 1'b1;
                    fwd = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (idle && !(ZeroEn && (a == '0))) begin
                rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = hit ? fwd : regs_q[a];
                rd_busy_o[i]                          = busy_q[a] && !hit;
            end
        end
    end

endmodule
